// File: rtl/sprite_line_writer_pkg.sv
// Shared video constants for the sprite line writer: attribute layout,
// sprite geometry and the FSM state encoding.
package sprite_line_writer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ATTR,
    S_CHECK,
    S_FETCH,
    S_WRITE,
    S_NEXT
  } slw_state_e;

  // byte offsets within one 4-byte attribute entry
  localparam int ATTR_CODE_LO = 0;
  localparam int ATTR_FLAGS   = 1;
  localparam int ATTR_XLO     = 2;
  localparam int ATTR_Y       = 3;

  // bit positions inside the flags byte
  localparam int FLG_CODE8 = 0;
  localparam int FLG_FLIPX = 4;
  localparam int FLG_FLIPY = 5;
  localparam int FLG_X8    = 7;

  localparam int          SPR_SIZE   = 16;
  localparam logic [3:0]  PIX_TRANSP = 4'h0;

  function automatic logic [7:0] line_offset(input logic [7:0] vpos,
                                             input logic [7:0] y);
    return vpos - y;
  endfunction

  function automatic logic on_line(input logic [7:0] r);
    return 32'(r) < SPR_SIZE;
  endfunction

endpackage

// File: rtl/sprite_line_writer_pix_shift.sv
// 8 x 4-bit pixel shifter; the first pixel of a freshly loaded word is
// presented in the load cycle itself so WRITE needs no extra latency.
module sprite_pix_shift (
  input  logic        clv,
  input  logic        RESET,
  input  logic        en,
  input  logic        load,
  input  logic        flip,
  input  logic [31:0] din,
  output logic [3:0]  pix
);

  logic [31:0] sreg;
  logic [31:0] src;

  assign src = load ? din : sreg;
  // flip emits pixel 7 first by draining from the low end
  assign pix = flip ? src[3:0] : src[31:28];

  always_ff @(posedge clv) begin
    if (RESET) begin
      sreg <= '0;
    end else if (en) begin
      sreg <= flip ? (src >> 4) : (src << 4);
    end
  end

endmodule

// File: rtl/sprite_line_writer.sv
// Scans NSPR sprite attribute entries for one scanline and writes the
// visible pixels of every on-line sprite into the selected line buffer bank.
module sprite_line_writer
  import sprite_line_writer_pkg::*;
#(
  parameter int         NSPR  = 48,
  parameter logic [7:0] SBASE = 8'h00
) (
  input  logic        clv,
  input  logic        RESET,
  input  logic        LSTART,
  input  logic [7:0]  VPOS,
  input  logic        LBANK,
  output logic [7:0]  SAD,
  input  logic [7:0]  SDT,
  output logic [13:0] GAD,
  input  logic [31:0] GDT,
  output logic        WEN,
  output logic [9:0]  WAD,
  output logic [3:0]  WDT,
  output logic        BUSY,
  output logic        DONE
);

  // state   | meaning
  // IDLE    | waiting for LSTART
  // ATTR    | four attribute reads, bytes captured one cycle later
  // CHECK   | y byte arrives; decide on-line and latch row
  // FETCH   | GAD driven for one pattern half
  // WRITE   | 8 pixels emitted, one per clock
  // NEXT    | advance sprite index or finish the line

  localparam int IW = (NSPR > 1) ? $clog2(NSPR) : 1;

  slw_state_e state, state_n;

  logic [IW-1:0] idx;
  logic [1:0]    bcnt;
  logic [2:0]    pcnt;
  logic          seg;
  logic [7:0]    vpos_r;
  logic          bank_r;
  logic [7:0]    code_lo;
  logic          code8;
  logic          flipx;
  logic          flipy;
  logic          x8;
  logic [7:0]    xlo;
  logic [3:0]    row;
  logic          done_r;

  logic [7:0]    r_off;
  logic          hit;
  logic          last;
  logic          half;
  logic [8:0]    xpos;
  logic [3:0]    pix;
  logic          sh_load;
  logic          sh_en;

  assign r_off   = line_offset(vpos_r, SDT);
  assign hit     = on_line(r_off);
  assign last    = (idx == IW'(NSPR - 1));
  // second fetch always lands at screen offset 8, whichever half it is
  assign half    = seg ^ flipx;
  assign xpos    = {x8, xlo} + {5'd0, seg, pcnt};
  assign sh_en   = (state == S_WRITE);
  assign sh_load = (state == S_WRITE) && (pcnt == 3'd0);

  sprite_pix_shift u_shift (
    .clv   (clv),
    .RESET (RESET),
    .en    (sh_en),
    .load  (sh_load),
    .flip  (flipx),
    .din   (GDT),
    .pix   (pix)
  );

  always_ff @(posedge clv) begin
    if (RESET) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    SAD     = SBASE + 8'({idx, 2'b00}) + 8'(bcnt);
    GAD     = '0;
    WEN     = 1'b0;
    WDT     = 4'h0;
    WAD     = {bank_r, 9'd0};
    BUSY    = (state != S_IDLE);
    DONE    = done_r;

    case (state)
      S_IDLE: begin
        state_n = S_IDLE;
      end
      S_ATTR: begin
        if (bcnt == 2'(ATTR_Y)) state_n = S_CHECK;
      end
      S_CHECK: begin
        state_n = hit ? S_FETCH : S_NEXT;
      end
      S_FETCH: begin
        GAD     = {code8, code_lo, row, half};
        state_n = S_WRITE;
      end
      S_WRITE: begin
        WEN = (pix != PIX_TRANSP);
        WDT = pix;
        WAD = {bank_r, xpos};
        if (pcnt == 3'd7) state_n = seg ? S_NEXT : S_FETCH;
      end
      S_NEXT: begin
        state_n = last ? S_IDLE : S_ATTR;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    if (LSTART) state_n = S_ATTR;
  end

  always_ff @(posedge clv) begin
    if (RESET) begin
      idx     <= '0;
      bcnt    <= '0;
      pcnt    <= '0;
      seg     <= 1'b0;
      vpos_r  <= '0;
      bank_r  <= 1'b0;
      code_lo <= '0;
      code8   <= 1'b0;
      flipx   <= 1'b0;
      flipy   <= 1'b0;
      x8      <= 1'b0;
      xlo     <= '0;
      row     <= '0;
      done_r  <= 1'b0;
    end else if (LSTART) begin
      // also the abort path: relatch and restart at sprite 0
      vpos_r <= VPOS;
      bank_r <= LBANK;
      idx    <= '0;
      bcnt   <= '0;
      pcnt   <= '0;
      seg    <= 1'b0;
      done_r <= 1'b0;
    end else begin
      done_r <= (state == S_NEXT) && last;
      case (state)
        S_ATTR: begin
          bcnt <= bcnt + 2'd1;
          if (bcnt == 2'(ATTR_CODE_LO + 1)) code_lo <= SDT;
          if (bcnt == 2'(ATTR_FLAGS + 1)) begin
            code8 <= SDT[FLG_CODE8];
            flipx <= SDT[FLG_FLIPX];
            flipy <= SDT[FLG_FLIPY];
            x8    <= SDT[FLG_X8];
          end
          if (bcnt == 2'(ATTR_XLO + 1)) xlo <= SDT;
        end
        S_CHECK: begin
          row  <= flipy ? ~r_off[3:0] : r_off[3:0];
          seg  <= 1'b0;
          pcnt <= '0;
          bcnt <= '0;
        end
        S_WRITE: begin
          pcnt <= pcnt + 3'd1;
          if (pcnt == 3'd7) seg <= ~seg;
        end
        S_NEXT: begin
          idx  <= last ? '0 : idx + IW'(1);
          bcnt <= '0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
